// File: rtl/sayuru_mem_arbiter_if.sv
// Bundle of the two master-side ports and the memory-side port of the arbiter.
// The arbiter uses the slave view; the requesters plus memory model use the master view.
interface sayuru_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic                  m0_req_i;
   logic                  m0_gnt_o;
   logic                  m0_rvalid_o;
   logic [ADDR_WIDTH-1:0] m0_addr_i;
   logic                  m0_we_i;
   logic [BE_WIDTH-1:0]   m0_be_i;
   logic [DATA_WIDTH-1:0] m0_wdata_i;
   logic [DATA_WIDTH-1:0] m0_rdata_o;

   logic                  m1_req_i;
   logic                  m1_gnt_o;
   logic                  m1_rvalid_o;
   logic [ADDR_WIDTH-1:0] m1_addr_i;
   logic                  m1_we_i;
   logic [BE_WIDTH-1:0]   m1_be_i;
   logic [DATA_WIDTH-1:0] m1_wdata_i;
   logic [DATA_WIDTH-1:0] m1_rdata_o;

   logic                  out_req_o;
   logic                  out_gnt_i;
   logic                  out_rvalid_i;
   logic [ADDR_WIDTH-1:0] out_addr_o;
   logic                  out_we_o;
   logic [BE_WIDTH-1:0]   out_be_o;
   logic [DATA_WIDTH-1:0] out_wdata_o;
   logic [DATA_WIDTH-1:0] out_rdata_i;

   modport slave (
      input  m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
      output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
      input  m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
      output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
      output out_req_o, out_addr_o, out_we_o, out_be_o, out_wdata_o,
      input  out_gnt_i, out_rvalid_i, out_rdata_i
   );

   modport master (
      output m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
      input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
      output m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
      input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
      input  out_req_o, out_addr_o, out_we_o, out_be_o, out_wdata_o,
      output out_gnt_i, out_rvalid_i, out_rdata_i
   );
endinterface

// File: rtl/sayuru_mem_arbiter.sv
// Round-robin two-master arbiter for the req/gnt/rvalid memory protocol with one
// transaction in flight, fully registered outputs and per-port performance counters.
module sayuru_mem_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   sayuru_mem_arbiter_if.slave bus,
   output logic [31:0]         grant0_count,
   output logic [31:0]         grant1_count,
   output logic [31:0]         contention_count
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;

   state_t                state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  last_grant_q, last_grant_d;
   logic                  req_q, req_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  we_q, we_d;
   logic [BE_WIDTH-1:0]   be_q, be_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [1:0]            gnt_q, gnt_d;
   logic [1:0]            rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
   logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
   logic [31:0]           g0_q, g0_d, g1_q, g1_d, cont_q, cont_d;
   logic                  winner;

   // Next-state logic; gnt/rvalid/rdata default to zero so every pulse lasts one cycle
   // and the port that is not being answered always sees zeros.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      req_d        = req_q;
      addr_d       = addr_q;
      we_d         = we_q;
      be_d         = be_q;
      wdata_d      = wdata_q;
      gnt_d        = '0;
      rvalid_d     = '0;
      rdata0_d     = '0;
      rdata1_d     = '0;
      g0_d         = g0_q;
      g1_d         = g1_q;
      cont_d       = cont_q;
      winner       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.m0_req_i || bus.m1_req_i) begin
               if (bus.m0_req_i && bus.m1_req_i) begin
                  winner = ~last_grant_q;
                  cont_d = cont_q + 32'd1;
               end else begin
                  winner = bus.m1_req_i;
               end
               owner_d = winner;
               req_d   = 1'b1;
               addr_d  = winner ? bus.m1_addr_i  : bus.m0_addr_i;
               we_d    = winner ? bus.m1_we_i    : bus.m0_we_i;
               be_d    = winner ? bus.m1_be_i    : bus.m0_be_i;
               wdata_d = winner ? bus.m1_wdata_i : bus.m0_wdata_i;
               state_d = WAIT_GNT;
            end
         end
         WAIT_GNT: begin
            if (bus.out_gnt_i) begin
               req_d            = 1'b0;
               addr_d           = '0;
               we_d             = 1'b0;
               be_d             = '0;
               wdata_d          = '0;
               gnt_d[owner_q]   = 1'b1;
               last_grant_d     = owner_q;
               if (owner_q) g1_d = g1_q + 32'd1;
               else         g0_d = g0_q + 32'd1;
               state_d          = WAIT_RVALID;
            end
         end
         WAIT_RVALID: begin
            if (bus.out_rvalid_i) begin
               rvalid_d[owner_q] = 1'b1;
               if (owner_q) rdata1_d = bus.out_rdata_i;
               else         rdata0_d = bus.out_rdata_i;
               state_d           = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; last_grant resets to 1 so port 0 wins the first tie.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         req_q        <= 1'b0;
         addr_q       <= '0;
         we_q         <= 1'b0;
         be_q         <= '0;
         wdata_q      <= '0;
         gnt_q        <= '0;
         rvalid_q     <= '0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         g0_q         <= '0;
         g1_q         <= '0;
         cont_q       <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         req_q        <= req_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         be_q         <= be_d;
         wdata_q      <= wdata_d;
         gnt_q        <= gnt_d;
         rvalid_q     <= rvalid_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         g0_q         <= g0_d;
         g1_q         <= g1_d;
         cont_q       <= cont_d;
      end
   end

   assign bus.out_req_o     = req_q;
   assign bus.out_addr_o    = addr_q;
   assign bus.out_we_o      = we_q;
   assign bus.out_be_o      = be_q;
   assign bus.out_wdata_o   = wdata_q;
   assign bus.m0_gnt_o      = gnt_q[0];
   assign bus.m1_gnt_o      = gnt_q[1];
   assign bus.m0_rvalid_o   = rvalid_q[0];
   assign bus.m1_rvalid_o   = rvalid_q[1];
   assign bus.m0_rdata_o    = rdata0_q;
   assign bus.m1_rdata_o    = rdata1_q;
   assign grant0_count      = g0_q;
   assign grant1_count      = g1_q;
   assign contention_count  = cont_q;
endmodule
